// File: rtl/taillight_input_conditioner_if.sv
// Switch-side and conditioned-output signals of the taillight input conditioner.
// The board side (master) drives the raw switches; the conditioner (slave) drives the rest.
interface taillight_input_conditioner_if;
    logic sw_left;
    logic sw_right;
    logic sw_bk;
    logic sw_haz;
    logic step_clk;
    logic step_tick;
    logic left;
    logic right;
    logic bk;
    logic haz;

    modport master (
        output sw_left, sw_right, sw_bk, sw_haz,
        input  step_clk, step_tick, left, right, bk, haz
    );

    modport slave (
        input  sw_left, sw_right, sw_bk, sw_haz,
        output step_clk, step_tick, left, right, bk, haz
    );
endinterface

// File: rtl/taillight_input_conditioner.sv
// Front end for the taillight sequencer: synchronises and debounces the raw switches, divides
// the board clock to the step clock, and holds the conditioned requests across each step.
module taillight_input_conditioner #(
    parameter int unsigned DIV_HALF        = 6250000,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter bit          HAZ_TOGGLE      = 1'b0
) (
    input logic                          clk,
    input logic                          rst_n,
    taillight_input_conditioner_if.slave bus
);
    localparam int unsigned     DbW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned     DivW    = $clog2(DIV_HALF + 1);
    localparam logic [DbW-1:0]  DbLast  = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DivW-1:0] DivLast = DivW'(DIV_HALF - 1);

    // Channel order: [0] left, [1] right, [2] bk, [3] haz.
    logic [3:0]      raw;
    logic [3:0]      sync1_q, sync2_q;
    logic [3:0]      stable_q, stable_d;
    logic [DbW-1:0]  db_cnt_q [4];
    logic [DbW-1:0]  db_cnt_d [4];
    logic [DivW-1:0] div_cnt_q, div_cnt_d;
    logic            step_clk_q, step_clk_d;
    logic            step_tick_q, step_tick_d;
    logic            div_wrap, step_fall;
    logic            haz_latch_q, haz_latch_d;
    logic            haz_src;
    logic [3:0]      out_q, out_d;

    assign raw = {bus.sw_haz, bus.sw_bk, bus.sw_right, bus.sw_left};

    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < 4; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (db_cnt_q[i] == DbLast) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
                end
            end
        end
    end

    always_comb begin
        div_wrap    = (div_cnt_q == DivLast);
        div_cnt_d   = div_wrap ? '0 : div_cnt_q + DivW'(1);
        step_clk_d  = step_clk_q ^ div_wrap;
        step_tick_d = div_wrap & ~step_clk_q;
        step_fall   = div_wrap & step_clk_q;
        // Next-state values so a change accepted on the falling step is captured there.
        haz_latch_d = haz_latch_q ^ (stable_d[3] & ~stable_q[3]);
        haz_src     = HAZ_TOGGLE ? haz_latch_d : stable_d[3];
        out_d       = step_fall ? {haz_src, stable_d[2:0]} : out_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            stable_q    <= '0;
            div_cnt_q   <= '0;
            step_clk_q  <= 1'b0;
            step_tick_q <= 1'b0;
            haz_latch_q <= 1'b0;
            out_q       <= '0;
            for (int i = 0; i < 4; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q     <= raw;
            sync2_q     <= sync1_q;
            stable_q    <= stable_d;
            div_cnt_q   <= div_cnt_d;
            step_clk_q  <= step_clk_d;
            step_tick_q <= step_tick_d;
            haz_latch_q <= haz_latch_d;
            out_q       <= out_d;
            for (int i = 0; i < 4; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
        end
    end

    assign bus.step_clk  = step_clk_q;
    assign bus.step_tick = step_tick_q;
    assign bus.left      = out_q[0];
    assign bus.right     = out_q[1];
    assign bus.bk        = out_q[2];
    assign bus.haz       = out_q[3];
endmodule

// File: doc/taillight_input_conditioner.md
Name: taillight_input_conditioner

Overview:
- Upstream front end for the taillight sequencer. Takes the raw board switches (left, right, brake, hazard) and the fast board clock.
- Synchronises and debounces each switch, and divides the board clock down to the slow step clock that paces the light sequence.
- Drives the conditioned left/right/bk/haz levels. These change only on the falling edge of the step clock, so they are stable at every step-clock rising edge.

Parameters:
- DIV_HALF, 6250000, board-clock cycles per step_clk half period (50 MHz -> 4 Hz step); legal range >= 1.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles needed to accept a new switch level (10 ms at 50 MHz); legal range >= 1.
- HAZ_TOGGLE, 0, 0: haz follows the debounced sw_haz level; 1: each debounced rising edge of sw_haz toggles haz.

Ports:
- clk  in  1  board clock; the only clock in the block.
- rst_n  in  1  synchronous, active-low reset.
- sw_left  in  1  raw left switch, asynchronous, may bounce.
- sw_right  in  1  raw right switch, asynchronous.
- sw_bk  in  1  raw brake switch, asynchronous.
- sw_haz  in  1  raw hazard switch or button, asynchronous.
- step_clk  out  1  divided square wave, 50% duty, period 2*DIV_HALF clk cycles; feeds the sequencer clock.
- step_tick  out  1  single-clk-cycle pulse, high in the first cycle step_clk reads 1.
- left  out  1  conditioned left request.
- right  out  1  conditioned right request.
- bk  out  1  conditioned brake request.
- haz  out  1  conditioned hazard request.

Behaviour:
- Reset (rst_n low at a clk rising edge): all outputs go to 0, step_clk goes to 0, all counters and synchroniser flops clear, and the haz toggle latch clears. This also applies mid-operation: at the next edge, a high step_clk drops low and any held outputs clear.
- Synchroniser: two flops per switch. The debounce stage sees a raw change 2 cycles later.
- Debounce, per channel:
  - Holds a stable bit and a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - If the sync value equals the stable bit, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, the stable bit takes the sync value and the counter clears.
  - Result: a change is accepted after exactly DEBOUNCE_CYCLES consecutive differing samples. Any shorter pulse is rejected.
- Divider:
  - div_cnt has width $clog2(DIV_HALF+1) and counts 0..DIV_HALF-1.
  - At DIV_HALF-1 it wraps to 0 and step_clk inverts. It never holds and has no overflow beyond the wrap.
  - The first step_clk rise comes DIV_HALF edges after reset release.
  - step_tick is asserted together with each 0->1 transition of step_clk. DIV_HALF=1 is legal: step_clk toggles every cycle.
- Hazard source:
  - HAZ_TOGGLE=0: the hazard source is the debounced sw_haz level.
  - HAZ_TOGGLE=1: a rising edge on the debounced sw_haz (stable bit 0->1) inverts the haz latch; a falling edge has no effect.
- Output hold register:
  - Loads in the cycle step_clk goes 1->0: left, right and bk take the debounced stable bits, and haz takes the hazard source.
  - Outputs change at no other time.
  - A debounced change that lands in the same cycle as the falling step is captured (the new value loads).
- No arbitration: conflicting requests (e.g. left and right together) pass through unchanged. Resolving them is the sequencer's job.
- Simultaneous raw edges on several switches debounce independently and appear on the same step_clk falling edge if all are accepted before it.
- Latency, raw change to output: 2 + DEBOUNCE_CYCLES cycles, then a wait for the next step_clk fall (worst case 2*DIV_HALF further cycles).

Test Plan (DIV_HALF=4, DEBOUNCE_CYCLES=8 unless stated):
- Reset: hold rst_n low 3 cycles, then release -> all outputs 0 during reset; step_clk rises 4 cycles after release, period 8; step_tick is a 1-cycle pulse every 8 cycles, aligned with each rise.
- Glitch rejection: drive sw_left high 5 cycles then low, repeat 3 times -> left stays 0 throughout.
- Clean press: drive sw_left high and hold -> internal stable bit sets 10 cycles later; left goes 1 exactly at the next step_clk 1->0 transition and never changes in between; release gives the mirror behaviour.
- Hazard toggle (HAZ_TOGGLE=1): two presses of sw_haz, each 12 cycles high with 20 cycles low between -> haz goes 0->1 at the first qualifying step_clk fall and back to 0 after the second press; a 5-cycle bounce pulse causes no toggle.
- Simultaneous inputs: raise sw_left and sw_bk in the same cycle -> left and bk assert at the same step_clk fall, with right=0 and haz=0.
- Mid-operation reset: with step_clk=1 and left=1, pull rst_n low for 1 cycle -> at the next edge all outputs, step_clk and step_tick are 0; with sw_left still high, left re-asserts only after the full debounce period plus the next step_clk fall.
